// File: rtl/mc_controller_ws.sv
// Multi-cycle MIPS-style control FSM with memory wait states, illegal-opcode traps and interrupts.
// Outputs are combinational from state and instruction fields and are held at zero during reset.
module mc_controller_ws #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter bit EXC_EN      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  input  logic       irq,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNe,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ExtOp,
  output logic       LuiOp,
  output logic       EPCWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] RegDst,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] ALUOp,
  output logic [1:0] Cause,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    StIf  = 3'd0,
    StId  = 3'd1,
    StEx  = 3'd2,
    StMem = 3'd3,
    StWb  = 3'd4,
    StExc = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic       irq_pending_q, irq_pending_d;
  logic [1:0] cause_q, cause_d;

  logic       is_rtype, is_ialu, is_lw, is_sw, is_branch, is_jump;
  logic       legal_funct, legal, fetch_done, mem_done;
  logic [3:0] alu_op_ex;

  assign is_rtype    = (OpCode == 6'h00);
  assign is_ialu     = OpCode inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0F};
  assign is_lw       = (OpCode == 6'h23);
  assign is_sw       = (OpCode == 6'h2B);
  assign is_branch   = OpCode inside {6'h04, 6'h05};
  assign is_jump     = OpCode inside {6'h02, 6'h03};
  assign legal_funct = Funct inside {6'h00, 6'h02, 6'h03, 6'h08, 6'h09, [6'h20:6'h27],
                                     6'h2A, 6'h2B};
  assign legal       = (is_rtype && legal_funct) || is_ialu || is_lw || is_sw ||
                       is_branch || is_jump;
  assign fetch_done  = mem_ready || !MEM_WAIT_EN;
  assign mem_done    = mem_ready || !MEM_WAIT_EN;

  always_comb begin
    alu_op_ex[3] = OpCode[0];
    if (is_rtype)                   alu_op_ex[2:0] = 3'b010;
    else if (is_branch)             alu_op_ex[2:0] = 3'b001;
    else if (OpCode == 6'h0C)       alu_op_ex[2:0] = 3'b100;
    else if (OpCode inside {6'h0A, 6'h0B}) alu_op_ex[2:0] = 3'b101;
    else                            alu_op_ex[2:0] = 3'b000;
  end

  always_comb begin
    state_d     = state_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNe    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ExtOp       = 1'b0;
    LuiOp       = 1'b0;
    EPCWrite    = 1'b0;
    MemtoReg    = 2'b00;
    RegDst      = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = 4'b0000;
    // Outputs stay at their zero defaults while reset is asserted.
    if (reset) begin
      case (state_q)
        StIf: begin
          if (EXC_EN && irq_pending_q) begin
            state_d = StExc;
          end else begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = fetch_done;
            PCWrite = fetch_done;
            if (fetch_done) state_d = StId;
          end
        end
        StId: begin
          ALUSrcB = 2'b11;
          ExtOp   = 1'b1;
          if (legal)       state_d = StEx;
          else if (EXC_EN) state_d = StExc;
          else             state_d = StIf;
        end
        StEx: begin
          ALUOp   = alu_op_ex;
          state_d = StIf;
          if (is_rtype) begin
            ALUSrcA = (Funct inside {6'h00, 6'h02, 6'h03}) ? 2'b10 : 2'b01;
            if (Funct inside {6'h08, 6'h09}) begin
              PCWrite = 1'b1;
              if (Funct == 6'h09) begin
                RegWrite = 1'b1;
                RegDst   = 2'b01;
                MemtoReg = 2'b10;
              end
            end else begin
              state_d = StWb;
            end
          end else if (is_ialu || is_lw || is_sw) begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            ExtOp   = (OpCode != 6'h0C);
            LuiOp   = (OpCode == 6'h0F);
            state_d = (is_lw || is_sw) ? StMem : StWb;
          end else if (is_branch) begin
            PCWriteCond = 1'b1;
            ALUSrcA     = 2'b01;
            PCSource    = 2'b01;
            BranchNe    = (OpCode == 6'h05);
          end else if (is_jump) begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
            if (OpCode == 6'h03) begin
              RegWrite = 1'b1;
              RegDst   = 2'b10;
              MemtoReg = 2'b10;
            end
          end
        end
        StMem: begin
          ALUOp    = alu_op_ex;
          IorD     = 1'b1;
          MemRead  = is_lw;
          MemWrite = is_sw;
          if (mem_done) state_d = is_lw ? StWb : StIf;
        end
        StWb: begin
          ALUOp    = alu_op_ex;
          RegWrite = 1'b1;
          MemtoReg = is_lw ? 2'b00 : 2'b01;
          RegDst   = is_rtype ? 2'b01 : 2'b00;
          state_d  = StIf;
        end
        StExc: begin
          EPCWrite = 1'b1;
          PCWrite  = 1'b1;
          PCSource = 2'b11;
          state_d  = StIf;
        end
        default: state_d = StIf;
      endcase
    end
  end

  // A new request on the entry edge survives the clear.
  assign irq_pending_d = irq || (irq_pending_q && (state_d != StExc));
  assign cause_d       = (state_d == StExc) ? ((state_q == StId) ? 2'b01 : 2'b10) : cause_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIf;
      irq_pending_q <= 1'b0;
      cause_q       <= 2'b00;
    end else begin
      state_q       <= state_d;
      irq_pending_q <= irq_pending_d;
      cause_q       <= cause_d;
    end
  end

  assign Cause   = cause_q;
  assign state_o = state_q;

endmodule

// File: doc/mc_controller_ws.md
MC_CONTROLLER_WS -- requirements
Module: mc_controller_ws

Interface
REQ-001 Parameter MEM_WAIT_EN, default 1, meaning: 1 = memory states stall on mem_ready; 0 = memory is single-cycle and mem_ready is ignored.
REQ-002 Parameter EXC_EN, default 1, meaning: 1 = illegal-instruction and interrupt handling enabled; 0 = illegal opcodes return to IF and irq is ignored.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-005 OpCode  in  6  IR[31:26]; Funct  in  6  IR[5:0]; both stable from ID onward.
REQ-006 mem_ready  in  1  memory completed the current read or write this cycle.
REQ-007 irq  in  1  external interrupt request, level, any cycle.
REQ-008 PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, LuiOp, EPCWrite  out  1 each  datapath enables/selects.
REQ-009 MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource  out  2 each; ALUOp  out  4; Cause  out  2 (registered); state_o  out  3.

Function
REQ-010 States: IF=0, ID=1, EX=2, MEM=3, WB=4, EXC=5; state_o = current state; codes 6-7 go to IF on the next edge.
REQ-011 Outputs are combinational from state, OpCode, Funct and mem_ready; any output not listed for a state is 0.
REQ-012 IF: MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, PCSource=00; IRWrite=PCWrite=(mem_ready or !MEM_WAIT_EN); advance to ID on that same condition, otherwise hold IF.
REQ-013 IF with irq_pending=1 and EXC_EN=1: all IF outputs 0, next state EXC; priority over the fetch.
REQ-014 irq_pending is set on any edge with irq=1 and cleared on the edge that enters EXC; set wins when both occur.
REQ-015 ID: ALUSrcA=00, ALUSrcB=11, ExtOp=1; next EX, or EXC if the instruction is illegal and EXC_EN=1, or IF if illegal and EXC_EN=0.
REQ-016 Legal: OpCode 00 with Funct in {00,02,03,08,09,20-27,2A,2B}; OpCode in {02,03,04,05,08,09,0A,0B,0C,0F,23,2B}.
REQ-017 EX R-type: ALUSrcA=10 for Funct 00/02/03, else 01; ALUSrcB=00; next WB. Funct 08: PCWrite=1, PCSource=00, next IF. Funct 09: additionally RegWrite=1, RegDst=01, MemtoReg=10.
REQ-018 EX I-type ALU (08,09,0A,0B,0C,0F) and lw/sw: ALUSrcA=01, ALUSrcB=10, ExtOp=(OpCode!=0C), LuiOp=(OpCode==0F); next WB for ALU ops, MEM for 23/2B.
REQ-019 EX beq/bne: PCWriteCond=1, ALUSrcA=01, ALUSrcB=00, PCSource=01, BranchNe=(OpCode==05); next IF.
REQ-020 EX j/jal: PCWrite=1, PCSource=10; jal also RegWrite=1, RegDst=10, MemtoReg=10; next IF.
REQ-021 MEM: IorD=1; MemRead=1 for lw, MemWrite=1 for sw; hold MEM until mem_ready=1 (or immediately if MEM_WAIT_EN=0); then WB for lw, IF for sw.
REQ-022 WB: RegWrite=1, MemtoReg=00 for lw, else 01; RegDst=01 for R-type, else 00; next IF.
REQ-023 EXC: EPCWrite=1, PCWrite=1, PCSource=11; Cause register loads 10 if entered from IF (irq), 01 if from ID (illegal); next IF.
REQ-024 ALUOp[3]=OpCode[0] and ALUOp[2:0] = 010 R-type, 001 beq/bne, 100 andi, 101 slti/sltiu, 000 otherwise, in EX/MEM/WB; ALUOp=0000 in IF, ID and EXC.

Reset
REQ-025 reset=0 forces state=IF, irq_pending=0, Cause=00 immediately (asynchronously), and forces every output to 0 for as long as reset=0, including mid-stall.
REQ-026 First rising edge after reset rises executes IF; a pending stall or memory operation is abandoned without completion.

Verification
REQ-027 add (00/20), mem_ready=1 always -> states 0,1,2,4,0; RegWrite=1, RegDst=01, MemtoReg=01 only in WB.
REQ-028 lw (23), MEM_WAIT_EN=1, mem_ready low 3 cycles in MEM -> state 3 held 4 cycles with MemRead=1, IorD=1; then WB with MemtoReg=00, RegWrite=1.
REQ-029 bne (05) -> EX shows PCWriteCond=1, BranchNe=1, PCSource=01, ALUOp=1001; next state 0.
REQ-030 OpCode 3F with EXC_EN=1 -> 0,1,5,0; EXC shows EPCWrite=1, PCSource=11; Cause=01 afterwards. With EXC_EN=0 -> 0,1,0, Cause stays 00.
REQ-031 irq pulsed 1 cycle during MEM of sw -> sw completes, next IF has IRWrite=0, then EXC, Cause=10, irq_pending cleared.
REQ-032 reset driven 0 mid-stall in MEM -> state_o=0 and all outputs 0 without waiting for clk; release -> normal fetch on the next edge.
